// File: rtl/countdown_sequencer.sv
// Control sequencer for a two-digit BCD countdown timer.
// It owns the editable preset and tells the datapath when to reload it.
// It gates the 1 Hz decrement enable, reacts to the front-panel buttons
// and times how long the buzzer alarm stays on.
module countdown_sequencer #(
    parameter logic [7:0]  PRESET_DEFAULT = 8'h20,
    parameter int unsigned ALARM_SECS     = 5
) (
    input  logic       clock_1,
    input  logic       reset,
    input  logic       tick,
    input  logic       btn_start,
    input  logic       btn_pause,
    input  logic       btn_inc,
    input  logic       btn_dec,
    input  logic       btn_clear,
    input  logic       count_zero,
    output logic       load,
    output logic [3:0] preset_h,
    output logic [3:0] preset_l,
    output logic       count_en,
    output logic       beep,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        ALARM = 2'd3
    } state_t;

    // The alarm ends on the tick that brings the counter up to ALARM_SECS,
    // so we compare against the count one below it.
    localparam logic [3:0] ALARM_LAST = 4'(ALARM_SECS - 1);

    state_t     state_q, state_d;
    logic [3:0] preset_h_q, preset_h_d;
    logic [3:0] preset_l_q, preset_l_d;
    logic [3:0] alarm_cnt_q, alarm_cnt_d;
    logic       load_q, load_d;
    logic       release_q;   // high for the first clock after reset drops
    logic       preset_nz;

    // BCD increment with units carry and 99 -> 00 wrap.
    function automatic logic [7:0] bcd_inc(input logic [3:0] h, input logic [3:0] l);
        logic [3:0] nh, nl;
        if (l == 4'd9) begin
            nl = 4'd0;
            nh = (h == 4'd9) ? 4'd0 : h + 4'd1;
        end else begin
            nl = l + 4'd1;
            nh = h;
        end
        return {nh, nl};
    endfunction

    // BCD decrement with units borrow and 00 -> 99 wrap.
    function automatic logic [7:0] bcd_dec(input logic [3:0] h, input logic [3:0] l);
        logic [3:0] nh, nl;
        if (l == 4'd0) begin
            nl = 4'd9;
            nh = (h == 4'd0) ? 4'd9 : h - 4'd1;
        end else begin
            nl = l - 4'd1;
            nh = h;
        end
        return {nh, nl};
    endfunction

    assign preset_nz = (preset_h_q != 4'd0) || (preset_l_q != 4'd0);

    // Next-state, preset editing, alarm timing and load request.
    always_comb begin
        state_d     = state_q;
        preset_h_d  = preset_h_q;
        preset_l_d  = preset_l_q;
        alarm_cnt_d = alarm_cnt_q;
        load_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (btn_clear) begin
                    preset_h_d = PRESET_DEFAULT[7:4];
                    preset_l_d = PRESET_DEFAULT[3:0];
                    load_d     = 1'b1;
                end else if (btn_start && preset_nz) begin
                    state_d = RUN;
                end else if (btn_inc && !btn_dec) begin
                    {preset_h_d, preset_l_d} = bcd_inc(preset_h_q, preset_l_q);
                    load_d = 1'b1;
                end else if (btn_dec && !btn_inc) begin
                    {preset_h_d, preset_l_d} = bcd_dec(preset_h_q, preset_l_q);
                    load_d = 1'b1;
                end
            end
            RUN: begin
                // Reaching zero wins over anything the user pressed this cycle.
                if (count_zero) begin
                    state_d     = ALARM;
                    alarm_cnt_d = 4'd0;
                end else if (btn_clear) begin
                    state_d = IDLE;
                    load_d  = 1'b1;
                end else if (btn_pause) begin
                    state_d = PAUSE;
                end
            end
            PAUSE: begin
                if (btn_clear) begin
                    state_d = IDLE;
                    load_d  = 1'b1;
                end else if (btn_start || btn_pause) begin
                    state_d = RUN;
                end
            end
            ALARM: begin
                // Clear here only acknowledges; the preset is left alone.
                if (btn_start || btn_pause || btn_clear) begin
                    state_d     = IDLE;
                    load_d      = 1'b1;
                    alarm_cnt_d = 4'd0;
                end else if (tick) begin
                    if (alarm_cnt_q == ALARM_LAST) begin
                        state_d     = IDLE;
                        load_d      = 1'b1;
                        alarm_cnt_d = 4'd0;
                    end else begin
                        alarm_cnt_d = alarm_cnt_q + 4'd1;
                    end
                end
            end
        endcase
    end

    // State, preset and load registers; load also fires once after reset.
    always_ff @(posedge clock_1) begin
        if (reset) begin
            state_q     <= IDLE;
            preset_h_q  <= PRESET_DEFAULT[7:4];
            preset_l_q  <= PRESET_DEFAULT[3:0];
            alarm_cnt_q <= 4'd0;
            load_q      <= 1'b0;
            release_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            preset_h_q  <= preset_h_d;
            preset_l_q  <= preset_l_d;
            alarm_cnt_q <= alarm_cnt_d;
            load_q      <= load_d | release_q;
            release_q   <= 1'b0;
        end
    end

    assign load     = load_q;
    assign preset_h = preset_h_q;
    assign preset_l = preset_l_q;
    assign state    = state_q;
    assign beep     = (state_q == ALARM);
    assign count_en = tick && (state_q == RUN) && !count_zero;

endmodule

// File: tb/tb_countdown_sequencer.sv
// Bench for countdown_sequencer: a directed walk through the front-panel
// scenarios followed by random button/tick/reset traffic. A reference model
// of the timer and a model of the BCD counter datapath produce the expected
// outputs each cycle; a monitor compares them against the DUT.
module tb_countdown_sequencer;

    localparam logic [7:0] PDEF  = 8'h20;
    localparam int         ASECS = 5;

    logic       clock_1 = 1'b0;
    logic       reset, tick, btn_start, btn_pause, btn_inc, btn_dec, btn_clear, count_zero;
    logic       load, count_en, beep;
    logic [3:0] preset_h, preset_l;
    logic [1:0] state;

    countdown_sequencer #(.PRESET_DEFAULT(PDEF), .ALARM_SECS(ASECS)) dut (
        .clock_1(clock_1), .reset(reset), .tick(tick),
        .btn_start(btn_start), .btn_pause(btn_pause), .btn_inc(btn_inc),
        .btn_dec(btn_dec), .btn_clear(btn_clear), .count_zero(count_zero),
        .load(load), .preset_h(preset_h), .preset_l(preset_l),
        .count_en(count_en), .beep(beep), .state(state)
    );

    always #5 clock_1 = ~clock_1;

    typedef struct {
        int         st;
        logic [7:0] pre;
        logic       ld;
        logic       bp;
        logic       ce;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: preset held as a plain integer 0..99.
    int m_st;     // 0 idle, 1 run, 2 pause, 3 alarm
    int m_p;
    int m_ac;     // ticks seen in alarm
    bit m_load;
    bit m_pend;   // load owed after reset release
    int dp;       // datapath count value (integer seconds)

    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] t, u;
        t = 4'(v / 10);
        u = 4'(v % 10);
        return {t, u};
    endfunction

    function automatic int pdef_int();
        logic [7:0] d;
        d = PDEF;
        return int'(d[7:4]) * 10 + int'(d[3:0]);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Monitor: every cycle presents an output; compare mid-cycle.
    always @(negedge clock_1) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("state",    int'(state),                  e.st);
            check("preset",   int'({preset_h, preset_l}),   int'(e.pre));
            check("load",     int'(load),                   int'(e.ld));
            check("beep",     int'(beep),                   int'(e.bp));
            check("count_en", int'(count_en),               int'(e.ce));
        end
    end

    // Apply one cycle of inputs, record the expected outputs, advance the model.
    task automatic drive(input bit st, input bit pa, input bit inc, input bit dec,
                         input bit clr, input bit tk, input bit rs);
        exp_t e;
        bit   cz, ce;
        int   nst, np, nac, ndp;
        bit   nl;
        cz = (dp == 0);
        btn_start = st; btn_pause = pa; btn_inc = inc; btn_dec = dec;
        btn_clear = clr; tick = tk; reset = rs; count_zero = cz;
        ce = tk && (m_st == 1) && !cz;
        e.st = m_st; e.pre = to_bcd(m_p); e.ld = m_load; e.bp = (m_st == 3); e.ce = ce;
        sb.push_back(e);

        // Datapath: loads the preset on load, otherwise counts down on enable.
        ndp = m_load ? m_p : (ce ? dp - 1 : dp);

        nst = m_st; np = m_p; nac = m_ac; nl = 1'b0;
        if (rs) begin
            nst = 0; np = pdef_int(); nac = 0; nl = 1'b0; m_pend = 1'b1;
        end else begin
            nl = m_pend;
            m_pend = 1'b0;
            if (m_st == 0) begin
                if (clr) begin
                    np = pdef_int(); nl = 1'b1;
                end else if (st && m_p != 0) begin
                    nst = 1;
                end else if (inc != dec) begin
                    np = inc ? (m_p + 1) % 100 : (m_p + 99) % 100;
                    nl = 1'b1;
                end
            end else if (m_st == 1) begin
                if (cz) begin nst = 3; nac = 0; end
                else if (clr) begin nst = 0; nl = 1'b1; end
                else if (pa) nst = 2;
            end else if (m_st == 2) begin
                if (clr) begin nst = 0; nl = 1'b1; end
                else if (st || pa) nst = 1;
            end else begin
                if (st || pa || clr) begin
                    nst = 0; nl = 1'b1; nac = 0;
                end else if (tk) begin
                    nac = m_ac + 1;
                    if (nac == ASECS) begin nst = 0; nl = 1'b1; nac = 0; end
                end
            end
        end
        m_st = nst; m_p = np; m_ac = nac; m_load = nl; dp = ndp;
        @(posedge clock_1);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            drive(0, 0, 0, 0, 0, 1, 0);
            idle(2);
        end
    endtask

    initial begin
        reset = 1'b1; tick = 0; btn_start = 0; btn_pause = 0; btn_inc = 0;
        btn_dec = 0; btn_clear = 0; count_zero = 0;
        @(posedge clock_1);
        #1;
        m_st = 0; m_p = pdef_int(); m_ac = 0; m_load = 1'b0; m_pend = 1'b1; dp = 20;

        // Reset release and the forced load pulse.
        drive(0, 0, 0, 0, 0, 0, 1);
        idle(3);

        // Walk preset down 20 -> 98, then wrap checks.
        for (int i = 0; i < 22; i++) begin drive(0, 0, 0, 1, 0, 0, 0); idle(1); end
        for (int i = 0; i < 3; i++)  begin drive(0, 0, 1, 0, 0, 0, 0); idle(1); end
        for (int i = 0; i < 2; i++)  begin drive(0, 0, 0, 1, 0, 0, 0); idle(1); end
        drive(0, 0, 1, 1, 0, 0, 0);
        idle(2);

        // Preset to 03, run down to the alarm and let it time out.
        for (int i = 0; i < 4; i++) begin drive(0, 0, 1, 0, 0, 0, 0); idle(1); end
        drive(1, 0, 0, 0, 0, 0, 0);
        ticks(4);
        ticks(5);
        idle(2);

        // Pause and resume, then acknowledge the alarm with clear.
        drive(1, 0, 0, 0, 0, 0, 0);
        ticks(1);
        drive(0, 1, 0, 0, 0, 0, 0);
        ticks(2);
        drive(1, 0, 0, 0, 0, 0, 0);
        ticks(3);
        ticks(2);
        drive(0, 0, 0, 0, 1, 0, 0);
        idle(2);

        // Preset 00 refuses to start.
        for (int i = 0; i < 3; i++) begin drive(0, 0, 0, 1, 0, 0, 0); idle(1); end
        drive(1, 0, 0, 0, 0, 0, 0);
        idle(2);

        // Reset in the middle of a run.
        drive(0, 0, 1, 0, 0, 0, 0);
        idle(1);
        drive(0, 0, 1, 0, 0, 0, 0);
        idle(1);
        drive(1, 0, 0, 0, 0, 0, 0);
        ticks(1);
        drive(0, 0, 0, 0, 0, 0, 1);
        idle(3);

        // Random traffic.
        for (int i = 0; i < 6000; i++) begin
            drive($urandom_range(0, 11) == 0, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 9) == 0,  $urandom_range(0, 9) == 0,
                  $urandom_range(0, 29) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 999) == 0);
        end

        @(negedge clock_1);
        #1;
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d entries left expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
